l0_stagger_buf: RTL and testbench
=================================

L0_STAGGER_BUF -- requirements
Module: l0_stagger_buf

Interface
REQ-001 Parameter ROW, default 8, number of row channels (>=2).
REQ-002 Parameter BW, default 4, bits per row entry.
REQ-003 Parameter DEPTH, default 64, entries per row FIFO (power of 2, >=4).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset; clears state immediately when low, released synchronously by design usage.
REQ-006 wr  input  1  push one ROW*BW word, one BW slice into each row FIFO.
REQ-007 in  input  ROW*BW  write data; row i = in[(i+1)*BW-1 : i*BW].
REQ-008 rd  input  1  read request injected into the read-enable pipeline.
REQ-009 rd_mode  input  1  0 = staggered (one row later per cycle), 1 = broadcast (all rows together).
REQ-010 out  output  ROW*BW  registered read data, same row slicing as in.
REQ-011 o_valid  output  ROW  o_valid[i] high for exactly the cycle after row i popped.
REQ-012 o_full  output  1  high when any row FIFO holds DEPTH entries.
REQ-013 o_ready  output  1  logical NOT of o_full.
REQ-014 o_empty  output  1  high when every row FIFO holds 0 entries.
REQ-015 o_err  output  2  sticky error flags {underflow, overflow}; see Configuration.

Function
REQ-016 Each row SHALL be an internal circular buffer of DEPTH entries with log2(DEPTH)+1-bit read/write pointers; full/empty from pointer MSB compare.
REQ-017 wr with o_full low SHALL write all ROW rows in the same edge; wr with o_full high SHALL be dropped in every row (no partial write).
REQ-018 Read-enable register rd_en[ROW-1:0]: staggered mode rd_en <= {rd_en[ROW-2:0], rd}; broadcast mode rd_en <= {ROW{rd}}.
REQ-019 Row i SHALL pop at the edge where rd_en[i] is 1 and row i is non-empty; out slice i and o_valid[i] update at that edge.
REQ-020 Latency: rd sampled at edge k -> row 0 data on out at edge k+1; staggered row i at edge k+1+i; broadcast all rows at edge k+1.
REQ-021 rd_en[i]=1 on empty row i: no pop, pointer unchanged, out slice i held, o_valid[i]=0.
REQ-022 Non-popping rows SHALL hold their out slice; o_valid[i] SHALL be 0.
REQ-023 Simultaneous write and pop on a row SHALL both take effect; occupancy unchanged; o_full evaluated on pre-edge occupancy for the write.
REQ-024 Pointers wrap modulo 2*DEPTH; no data loss across wrap.
REQ-025 rd_mode SHALL be latched into an internal mode register only when rd_en is all-zero and rd is low; otherwise the previous mode stays in force.
REQ-026 o_full, o_ready, o_empty SHALL be combinational from current pointers.

Reset
REQ-027 reset low SHALL asynchronously clear all pointers, rd_en, mode register (staggered), out, o_valid, o_err.
REQ-028 After reset: o_empty=1, o_full=0, o_ready=1, out=0, o_valid=0, o_err=0.
REQ-029 reset asserted mid-operation SHALL discard all stored entries and in-flight read enables; no pop occurs at or after the asserting edge.

Configuration
REQ-030 Macro L0_STAGGER_ERR_FLAG_EN defined: o_err[0] sets on a wr dropped due to o_full; o_err[1] sets on any rd_en[i]=1 with row i empty; flags sticky until reset.
REQ-031 Macro absent: o_err SHALL be tied to 2'b00 and no error logic synthesised; all other behaviour identical.

Verification
REQ-032 Reset, then 4 writes in=0x87654321..., rd_mode=0, one rd pulse -> o_valid walks 0x01,0x02,...,0x80 over 8 consecutive cycles, out slice i = row-i nibble of first word.
REQ-033 rd_mode=1, 2 words written, rd held 2 cycles -> o_valid=0xFF for 2 cycles, out = word0 then word1.
REQ-034 DEPTH writes -> o_full=1, o_ready=0; extra wr with new data dropped; with ERR_FLAG_EN o_err=2'b01; draining returns exact DEPTH words in order.
REQ-035 rd on empty buffer -> o_valid=0, out unchanged, with ERR_FLAG_EN o_err[1]=1.
REQ-036 Write/read 3*DEPTH words streaming with simultaneous wr and rd -> in-order data across pointer wrap, occupancy constant.
REQ-037 Assert reset mid-staggered read (rd_en=0x0E) -> outputs to reset values immediately; no further o_valid pulses after release.

Source files
------------

// File: rtl/l0_stagger_buf.sv
// Per-row FIFO buffer with a staggered or broadcast read-enable pipeline.
// Optional sticky error flags are enabled by defining L0_STAGGER_ERR_FLAG_EN.
module l0_stagger_buf #(
  parameter int ROW   = 8,
  parameter int BW    = 4,
  parameter int DEPTH = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr,
  input  logic [ROW*BW-1:0] in,
  input  logic              rd,
  input  logic              rd_mode,
  output logic [ROW*BW-1:0] out,
  output logic [ROW-1:0]    o_valid,
  output logic              o_full,
  output logic              o_ready,
  output logic              o_empty,
  output logic [1:0]        o_err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_INC = (AW+1)'(1);

  logic [BW-1:0] mem_r [ROW][DEPTH];
  logic [AW:0]   wr_ptr_r [ROW];
  logic [AW:0]   rd_ptr_r [ROW];
  logic [ROW-1:0] rd_en_r;
  logic           mode_r;

  logic [ROW-1:0] empty_s;
  logic [ROW-1:0] full_s;
  logic [ROW-1:0] pop_s;
  logic           push_s;

  // Per-row occupancy flags and pop qualification from the current pointers
  always_comb begin
    empty_s = '0;
    full_s  = '0;
    pop_s   = '0;
    for (int i = 0; i < ROW; i++) begin
      empty_s[i] = (wr_ptr_r[i] == rd_ptr_r[i]);
      full_s[i]  = (wr_ptr_r[i][AW] != rd_ptr_r[i][AW]) &&
                   (wr_ptr_r[i][AW-1:0] == rd_ptr_r[i][AW-1:0]);
      pop_s[i]   = rd_en_r[i] & ~empty_s[i];
    end
  end

  // A write is all-or-nothing: any full row blocks every row
  assign push_s  = wr & ~o_full;
  assign o_full  = |full_s;
  assign o_ready = ~o_full;
  assign o_empty = &empty_s;

  // Storage array; contents need no reset since pointers define validity
  always_ff @(posedge clk) begin
    for (int i = 0; i < ROW; i++) begin
      if (push_s) begin
        mem_r[i][wr_ptr_r[i][AW-1:0]] <= in[i*BW +: BW];
      end
    end
  end

  // Pointers, read-enable pipeline, mode register and registered read data
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < ROW; i++) begin
        wr_ptr_r[i] <= '0;
        rd_ptr_r[i] <= '0;
      end
      rd_en_r <= '0;
      mode_r  <= 1'b0;
      out     <= '0;
      o_valid <= '0;
    end else begin
      for (int i = 0; i < ROW; i++) begin
        if (push_s) begin
          wr_ptr_r[i] <= wr_ptr_r[i] + PTR_INC;
        end
        if (pop_s[i]) begin
          rd_ptr_r[i]       <= rd_ptr_r[i] + PTR_INC;
          out[i*BW +: BW]   <= mem_r[i][rd_ptr_r[i][AW-1:0]];
        end
      end
      o_valid <= pop_s;
      if (mode_r) begin
        rd_en_r <= {ROW{rd}};
      end else begin
        rd_en_r <= {rd_en_r[ROW-2:0], rd};
      end
      // Mode only changes while no read is in flight, so a burst never mixes modes
      if ((rd_en_r == '0) && !rd) begin
        mode_r <= rd_mode;
      end
    end
  end

`ifdef L0_STAGGER_ERR_FLAG_EN
  logic [1:0] err_r;

  // Sticky {underflow, overflow} flags, cleared only by reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_r <= 2'b00;
    end else begin
      if (wr && o_full) begin
        err_r[0] <= 1'b1;
      end
      if ((rd_en_r & empty_s) != '0) begin
        err_r[1] <= 1'b1;
      end
    end
  end

  assign o_err = err_r;
`else
  assign o_err = 2'b00;
`endif

endmodule

// File: tb/tb_l0_stagger_buf.sv
// Directed self-checking bench for l0_stagger_buf (ROW=8, BW=4, DEPTH=64).
module tb_l0_stagger_buf;

  localparam int ROW   = 8;
  localparam int BW    = 4;
  localparam int DEPTH = 64;
`ifdef L0_STAGGER_ERR_FLAG_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic              clk;
  logic              reset;
  logic              wr;
  logic [ROW*BW-1:0] in;
  logic              rd;
  logic              rd_mode;
  logic [ROW*BW-1:0] out;
  logic [ROW-1:0]    o_valid;
  logic              o_full;
  logic              o_ready;
  logic              o_empty;
  logic [1:0]        o_err;

  int checks_r;
  int failures_r;

  l0_stagger_buf #(.ROW(ROW), .BW(BW), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .reset   (reset),
    .wr      (wr),
    .in      (in),
    .rd      (rd),
    .rd_mode (rd_mode),
    .out     (out),
    .o_valid (o_valid),
    .o_full  (o_full),
    .o_ready (o_ready),
    .o_empty (o_empty),
    .o_err   (o_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_r++;
    if (obs !== exp) begin
      failures_r++;
      $display("FAIL %s: obs=0x%08h exp=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] dat(input int j);
    logic [31:0] t;
    t = j + 1;
    return t * 32'h9E3779B9;
  endfunction

  logic [31:0] w [4];
  logic [31:0] err_exp;

  initial begin
    checks_r   = 0;
    failures_r = 0;
    w[0] = 32'h87654321;
    w[1] = 32'h12345678;
    w[2] = 32'hA5A5F00F;
    w[3] = 32'hDEADBEEF;
    reset = 1'b0; wr = 1'b0; rd = 1'b0; rd_mode = 1'b0; in = '0;
    #2;
    check_eq("rst_empty", 32'(o_empty), 32'd1);
    check_eq("rst_full",  32'(o_full),  32'd0);
    check_eq("rst_ready", 32'(o_ready), 32'd1);
    check_eq("rst_out",   out,          32'h0);
    check_eq("rst_valid", 32'(o_valid), 32'h0);
    check_eq("rst_err",   32'(o_err),   32'h0);
    tick(); tick();
    reset = 1'b1;

    // Staggered read of the first word across all rows
    for (int j = 0; j < 4; j++) begin
      wr = 1'b1; in = w[j];
      tick();
    end
    wr = 1'b0; rd = 1'b1;
    tick();
    rd = 1'b0;
    for (int i = 0; i < ROW; i++) begin
      tick();
      check_eq($sformatf("stag_valid%0d", i), 32'(o_valid), 32'h1 << i);
      check_eq($sformatf("stag_out%0d", i), out, w[0] & (32'hFFFFFFFF >> (28 - 4*i)));
    end
    rd_mode = 1'b1;
    tick();
    check_eq("stag_done_valid", 32'(o_valid), 32'h0);

    // Broadcast read of the remaining three words
    rd = 1'b1;
    tick();
    check_eq("bc_first_valid", 32'(o_valid), 32'h0);
    for (int j = 1; j < 4; j++) begin
      if (j == 3) rd = 1'b0;
      tick();
      check_eq($sformatf("bc_out%0d", j), out, w[j]);
      check_eq($sformatf("bc_valid%0d", j), 32'(o_valid), 32'hFF);
    end
    check_eq("bc_empty", 32'(o_empty), 32'd1);

    // Fill to DEPTH, drop an extra write, then drain in order
    for (int j = 0; j < DEPTH; j++) begin
      wr = 1'b1; in = dat(j);
      tick();
      if (j == DEPTH - 2) check_eq("fill_notfull", 32'(o_full), 32'd0);
    end
    check_eq("fill_full",  32'(o_full),  32'd1);
    check_eq("fill_ready", 32'(o_ready), 32'd0);
    in = 32'hFFFFFFFF;
    tick();
    wr = 1'b0;
    err_exp = ERR_EN ? 32'h1 : 32'h0;
    check_eq("ovf_err",  32'(o_err),  err_exp);
    check_eq("ovf_full", 32'(o_full), 32'd1);
    rd = 1'b1;
    tick();
    for (int j = 0; j < DEPTH; j++) begin
      if (j == DEPTH - 1) rd = 1'b0;
      tick();
      check_eq($sformatf("drain%0d", j), out, dat(j));
      if (j == 0) check_eq("drain_ready", 32'(o_ready), 32'd1);
    end
    tick();
    check_eq("drain_valid", 32'(o_valid), 32'h0);
    check_eq("drain_empty", 32'(o_empty), 32'd1);

    // Streaming write+read across pointer wrap with occupancy of one
    for (int n = 0; n <= 3*DEPTH; n++) begin
      wr = (n < 3*DEPTH); rd = (n < 3*DEPTH); in = dat(n + 100);
      tick();
      if (n >= 1) check_eq($sformatf("strm%0d", n-1), out, dat(n + 99));
      if (n == DEPTH) check_eq("strm_nonempty", 32'(o_empty), 32'd0);
    end
    wr = 1'b0; rd = 1'b0;
    check_eq("strm_empty", 32'(o_empty), 32'd1);
    check_eq("strm_err",   32'(o_err),   err_exp);

    // Read on an empty buffer
    rd = 1'b1;
    tick();
    rd = 1'b0;
    tick();
    check_eq("udf_valid", 32'(o_valid), 32'h0);
    check_eq("udf_out",   out,          dat(3*DEPTH + 99));
    err_exp = ERR_EN ? 32'h3 : 32'h0;
    check_eq("udf_err",   32'(o_err),   err_exp);

    // Reset in the middle of a staggered read (rd_en = 0x0E)
    rd_mode = 1'b0;
    tick();
    for (int j = 0; j < 4; j++) begin
      wr = 1'b1; in = w[j];
      tick();
    end
    wr = 1'b0; rd = 1'b1;
    tick(); tick(); tick();
    rd = 1'b0;
    tick();
    check_eq("mid_valid", 32'(o_valid), 32'h07);
    reset = 1'b0;
    #1;
    check_eq("mrst_out",   out,          32'h0);
    check_eq("mrst_valid", 32'(o_valid), 32'h0);
    check_eq("mrst_empty", 32'(o_empty), 32'd1);
    check_eq("mrst_full",  32'(o_full),  32'd0);
    check_eq("mrst_err",   32'(o_err),   32'h0);
    tick(); tick();
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_eq($sformatf("post_valid%0d", i), 32'(o_valid), 32'h0);
    end
    check_eq("post_out", out, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks_r, failures_r);
    $finish;
  end

endmodule
